// File: rtl/usb_rx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_rx_pkg: shared state type and line defaults for the USB FS rx path    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package usb_rx_pkg;

  localparam logic        USB_J_LVL     = 1'b1;
  localparam int unsigned USB_STUFF_LEN = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    STUFF = 2'd2,
    ERROR = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/usb_rx_deser.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_rx_deser: LSB-first word assembly with bit count and held output word |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module usb_rx_deser #(
  parameter int unsigned DATA_W = 8
) (
  input  logic                              clk,
  input  logic                              n_rst,
  input  logic                              clr_i,
  input  logic                              strobe_i,
  input  logic                              bit_i,
  output logic [$clog2(DATA_W + 1)-1:0]     bit_cnt_o,
  output logic [DATA_W-1:0]                 word_out_o,
  output logic                              word_valid_o
);

  localparam int unsigned c_cnt_w = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]  sreg_q, sreg_d;
  logic [c_cnt_w-1:0] bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]  word_q, word_d;
  logic               word_valid_q, word_valid_d;
  logic [DATA_W-1:0]  w_shifted;

  assign w_shifted = {bit_i, sreg_q[DATA_W-1:1]};

  always_comb begin
    sreg_d       = sreg_q;
    bit_cnt_d    = bit_cnt_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    if (clr_i) begin
      sreg_d    = '0;
      bit_cnt_d = '0;
    end else if (strobe_i) begin
      sreg_d = w_shifted;
      // The completing bit is taken straight from the shift path so the word
      // appears on the same edge as that bit's bit_valid.
      if (bit_cnt_q == c_cnt_w'(DATA_W - 1)) begin
        bit_cnt_d    = '0;
        word_d       = w_shifted;
        word_valid_d = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + c_cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      sreg_q       <= '0;
      bit_cnt_q    <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      sreg_q       <= sreg_d;
      bit_cnt_q    <= bit_cnt_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  assign bit_cnt_o    = bit_cnt_q;
  assign word_out_o   = word_q;
  assign word_valid_o = word_valid_q;

endmodule
`default_nettype wire

// File: rtl/usb_rx_nrzi_unstuff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | usb_rx_nrzi_unstuff: NRZI decode, bit unstuffing, stuff-error detection   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module usb_rx_nrzi_unstuff
  import usb_rx_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned STUFF_LEN = USB_STUFF_LEN,
  parameter logic        IDLE_LVL  = USB_J_LVL
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              d_plus,
  input  logic              shift_enable,
  input  logic              eop,
  input  logic              rcving,
  output logic              d_orig,
  output logic              bit_valid,
  output logic [DATA_W-1:0] word_out,
  output logic              word_valid,
  output logic              stuff_err,
  output logic              partial_err
);

  localparam int unsigned c_ones_w = $clog2(STUFF_LEN + 1);
  localparam int unsigned c_cnt_w  = $clog2(DATA_W + 1);

  rx_state_e           state_q, state_d;
  logic                prev_lvl_q, prev_lvl_d;
  logic                d_orig_q, d_orig_d;
  logic [c_ones_w-1:0] ones_cnt_q, ones_cnt_d;
  logic                bit_valid_q, bit_valid_d;
  logic                stuff_err_q, stuff_err_d;
  logic                partial_err_q, partial_err_d;

  logic                w_dec_bit;
  logic [c_ones_w-1:0] w_ones_inc;
  logic                w_ds_clr;
  logic                w_ds_strobe;
  logic [c_cnt_w-1:0]  w_bit_cnt;

  assign w_dec_bit  = (d_plus == prev_lvl_q);
  assign w_ones_inc = ones_cnt_q + c_ones_w'(1);

  always_comb begin
    state_d       = state_q;
    prev_lvl_d    = prev_lvl_q;
    d_orig_d      = d_orig_q;
    ones_cnt_d    = ones_cnt_q;
    bit_valid_d   = 1'b0;
    stuff_err_d   = 1'b0;
    partial_err_d = 1'b0;
    w_ds_clr      = 1'b0;
    w_ds_strobe   = 1'b0;

    if (!rcving) begin
      state_d    = IDLE;
      prev_lvl_d = IDLE_LVL;
      d_orig_d   = 1'b1;
      ones_cnt_d = '0;
      w_ds_clr   = 1'b1;
    end else if (eop && shift_enable) begin
      prev_lvl_d = IDLE_LVL;
      d_orig_d   = 1'b1;
      ones_cnt_d = '0;
      w_ds_clr   = 1'b1;
      state_d    = IDLE;
      if ((state_q == RECV || state_q == STUFF) && w_bit_cnt != '0)
        partial_err_d = 1'b1;
    end else if (shift_enable) begin
      prev_lvl_d = d_plus;
      d_orig_d   = w_dec_bit;
      case (state_q)
        // IDLE with rcving high treats a same-cycle strobe as the first data bit.
        IDLE, RECV: begin
          state_d     = RECV;
          w_ds_strobe = 1'b1;
          bit_valid_d = 1'b1;
          if (w_dec_bit) begin
            ones_cnt_d = w_ones_inc;
            if (w_ones_inc == c_ones_w'(STUFF_LEN))
              state_d = STUFF;
          end else begin
            ones_cnt_d = '0;
          end
        end
        STUFF: begin
          ones_cnt_d = '0;
          if (w_dec_bit) begin
            stuff_err_d = 1'b1;
            state_d     = ERROR;
          end else begin
            state_d = RECV;
          end
        end
        default: ;
      endcase
    end else if (state_q == IDLE) begin
      state_d = RECV;
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      prev_lvl_q    <= IDLE_LVL;
      d_orig_q      <= 1'b1;
      ones_cnt_q    <= '0;
      bit_valid_q   <= 1'b0;
      stuff_err_q   <= 1'b0;
      partial_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      prev_lvl_q    <= prev_lvl_d;
      d_orig_q      <= d_orig_d;
      ones_cnt_q    <= ones_cnt_d;
      bit_valid_q   <= bit_valid_d;
      stuff_err_q   <= stuff_err_d;
      partial_err_q <= partial_err_d;
    end
  end

  usb_rx_deser #(
    .DATA_W (DATA_W)
  ) u_deser (
    .clk          (clk),
    .n_rst        (n_rst),
    .clr_i        (w_ds_clr),
    .strobe_i     (w_ds_strobe),
    .bit_i        (w_dec_bit),
    .bit_cnt_o    (w_bit_cnt),
    .word_out_o   (word_out),
    .word_valid_o (word_valid)
  );

  assign d_orig      = d_orig_q;
  assign bit_valid   = bit_valid_q;
  assign stuff_err   = stuff_err_q;
  assign partial_err = partial_err_q;

endmodule
`default_nettype wire

// File: tb/tb_usb_rx_nrzi_unstuff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_usb_rx_nrzi_unstuff: directed and randomized line stimulus vs model    |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_usb_rx_nrzi_unstuff;

  localparam int DW = 8;
  localparam int SL = 6;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          d_plus = 1'b1;
  logic          shift_enable = 1'b0;
  logic          eop = 1'b0;
  logic          rcving = 1'b0;
  logic          d_orig;
  logic          bit_valid;
  logic [DW-1:0] word_out;
  logic          word_valid;
  logic          stuff_err;
  logic          partial_err;

  usb_rx_nrzi_unstuff #(
    .DATA_W    (DW),
    .STUFF_LEN (SL),
    .IDLE_LVL  (1'b1)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .d_plus       (d_plus),
    .shift_enable (shift_enable),
    .eop          (eop),
    .rcving       (rcving),
    .d_orig       (d_orig),
    .bit_valid    (bit_valid),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .stuff_err    (stuff_err),
    .partial_err  (partial_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int n_bv, n_wv, n_se, n_pe;

  // Reference: line level history, run of decoded ones, queue of data bits.
  logic          m_prev, m_dorig;
  int            m_ones;
  bit            m_expect_stuff, m_dead;
  bit            m_bits[$];
  logic [DW-1:0] m_wout;
  bit            e_bv, e_wv, e_se, e_pe;
  logic          tx_lvl;
  int            tx_ones;
  logic          last_dp;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prev = 1'b1; m_dorig = 1'b1; m_ones = 0;
    m_expect_stuff = 0; m_dead = 0; m_bits.delete(); m_wout = '0;
    e_bv = 0; e_wv = 0; e_se = 0; e_pe = 0;
  endtask

  task automatic model_step(input logic se, input logic eo, input logic rv, input logic dp);
    bit b;
    e_bv = 0; e_wv = 0; e_se = 0; e_pe = 0;
    if (!rv) begin
      m_prev = 1'b1; m_dorig = 1'b1; m_ones = 0;
      m_expect_stuff = 0; m_dead = 0; m_bits.delete();
    end else if (eo && se) begin
      if (!m_dead && m_bits.size() != 0) e_pe = 1;
      m_prev = 1'b1; m_dorig = 1'b1; m_ones = 0;
      m_expect_stuff = 0; m_dead = 0; m_bits.delete();
    end else if (se) begin
      b = (dp == m_prev);
      m_prev = dp; m_dorig = b;
      if (m_dead) begin
      end else if (m_expect_stuff) begin
        m_expect_stuff = 0; m_ones = 0;
        if (b) begin e_se = 1; m_dead = 1; end
      end else begin
        m_bits.push_back(b);
        e_bv = 1;
        m_ones = b ? m_ones + 1 : 0;
        if (m_ones == SL) m_expect_stuff = 1;
        if (m_bits.size() == DW) begin
          for (int i = 0; i < DW; i++) m_wout[i] = m_bits[i];
          e_wv = 1;
          m_bits.delete();
        end
      end
    end
  endtask

  task automatic compare_outputs();
    chk("d_orig", d_orig, m_dorig);
    chk("bit_valid", bit_valid, e_bv);
    chk("word_valid", word_valid, e_wv);
    chk("word_out", word_out, m_wout);
    chk("stuff_err", stuff_err, e_se);
    chk("partial_err", partial_err, e_pe);
    n_bv += bit_valid; n_wv += word_valid; n_se += stuff_err; n_pe += partial_err;
  endtask

  task automatic step(input logic se, input logic eo, input logic rv, input logic dp);
    shift_enable = se; eop = eo; rcving = rv; d_plus = dp; last_dp = dp;
    model_step(se, eo, rv, dp);
    @(posedge clk); #1;
    compare_outputs();
  endtask

  task automatic pulse_reset();
    n_rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    compare_outputs();
    n_rst = 1'b1;
  endtask

  task automatic clr_cnt();
    n_bv = 0; n_wv = 0; n_se = 0; n_pe = 0;
  endtask

  task automatic strobe(input logic lvl);
    step(1'b1, 1'b0, 1'b1, lvl);
    repeat ($urandom_range(0, 1)) step(1'b0, 1'b0, 1'b1, lvl);
  endtask

  task automatic send_raw(input logic [31:0] line, input int n);
    for (int i = 0; i < n; i++) strobe(line[i]);
  endtask

  // NRZI-encode one byte LSB-first with bit stuffing from the bench side.
  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (!b[i]) begin tx_lvl = ~tx_lvl; tx_ones = 0; end
      else tx_ones++;
      strobe(tx_lvl);
      if (tx_ones == SL) begin
        tx_lvl = ~tx_lvl; tx_ones = 0;
        strobe(tx_lvl);
      end
    end
  endtask

  task automatic open_pkt();
    tx_lvl = 1'b1; tx_ones = 0;
    step(1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic close_pkt();
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    clr_cnt();
    @(posedge clk); #1;
    pulse_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);

    clr_cnt(); open_pkt();
    send_raw(32'h0C9, 8);
    chk("A5_bits", n_bv, 8); chk("A5_words", n_wv, 1); chk("A5_word", word_out, 8'hA5);
    close_pkt();

    clr_cnt(); open_pkt();
    send_raw(32'h03F, 9);
    chk("FF_bits", n_bv, 8); chk("FF_word", word_out, 8'hFF); chk("FF_serr", n_se, 0);
    close_pkt();

    clr_cnt(); open_pkt();
    send_raw(32'h07F, 7);
    chk("err_pulse", n_se, 1);
    send_raw(32'h00A, 6);
    chk("err_bits", n_bv, 6); chk("err_words", n_wv, 0);
    close_pkt();

    clr_cnt(); open_pkt();
    send_raw(32'h001, 3);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    chk("part_pulse", n_pe, 1); chk("part_words", n_wv, 0); chk("part_dorig", d_orig, 1'b1);
    tx_lvl = 1'b1; tx_ones = 0;
    send_byte(8'h5A);
    chk("after_eop_word", word_out, 8'h5A);
    close_pkt();

    clr_cnt(); open_pkt();
    send_raw(32'h015, 5);
    close_pkt();
    open_pkt();
    send_byte(8'hA5);
    chk("drop_words", n_wv, 1); chk("drop_word", word_out, 8'hA5);
    close_pkt();

    clr_cnt(); open_pkt();
    send_raw(32'h009, 4);
    pulse_reset();
    chk("rst_word", word_out, 8'h00); chk("rst_dorig", d_orig, 1'b1);
    tx_lvl = 1'b1; tx_ones = 0;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    send_byte(8'h3C);
    chk("rst_3C", word_out, 8'h3C);
    close_pkt();

    // Randomized packets: encoded bytes, optional raw noise, eop or drop.
    for (int p = 0; p < 40; p++) begin
      open_pkt();
      repeat ($urandom_range(1, 3)) send_byte(8'($urandom));
      if ($urandom_range(0, 2) == 0) send_raw($urandom | 32'h0000_00FF, $urandom_range(1, 12));
      if ($urandom_range(0, 9) == 0) pulse_reset();
      if ($urandom_range(0, 1) == 0) step(1'b1, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 1'b1, 1'b1);
      close_pkt();
    end

    // Free-running noise on all inputs, line biased to hold its level.
    last_dp = 1'b1;
    for (int c = 0; c < 1200; c++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      else step($urandom_range(0, 1) == 1,
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 49) != 0,
                ($urandom_range(0, 3) == 0) ? ~last_dp : last_dp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
